// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake and instruction-memory write port between the host
// boot path and the toycpu instruction encoder/loader.
`timescale 1ns/1ps
interface instr_encoder_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [1:0]            in_rd;
    logic [1:0]            in_rs1;
    logic [1:0]            in_rs2;
    logic [6:0]            in_aluop;
    logic [15:0]           in_imm;
    logic                  in_flag;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [15:0]           imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_aluop, in_imm, in_flag,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_aluop, in_imm, in_flag,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs symbolic toycpu instruction descriptors into 16-bit words and writes
// them to instruction memory at consecutive addresses, one word per two cycles.
`timescale 1ns/1ps
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_encoder_loader_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam logic [2:0] OP_ALU = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_LD  = 3'd2;
    localparam logic [2:0] OP_ST  = 3'd3;
    localparam logic [2:0] OP_BRC = 3'd4;
    localparam logic [2:0] OP_BRZ = 3'd5;
    localparam logic [2:0] OP_END = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam logic [1:0] ERR_RSV      = 2'b00;
    localparam logic [1:0] ERR_LDI      = 2'b01;
    localparam logic [1:0] ERR_BRANCH   = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_STEP = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} loaderState_t;

    loaderState_t          state, nextState;
    logic                  accept, setDone, setErr;
    logic [1:0]            nextCode;
    logic                  ldiOutOfRange, branchOutOfRange;
    logic [ADDR_WIDTH-1:0] addrPtr;
    logic                  imemWe;
    logic [ADDR_WIDTH-1:0] imemAddr;
    logic [15:0]           imemWdata;

    function automatic logic [15:0] encode(
        input logic [2:0]  op,
        input logic [1:0]  rd,
        input logic [1:0]  rs1,
        input logic [1:0]  rs2,
        input logic [6:0]  aluop,
        input logic [10:0] immLow,
        input logic        flag
    );
        logic [15:0] word;
        case (op)
            OP_ALU:  word = {3'b000, rd, rs1, rs2, aluop};
            OP_LDI:  word = {3'b001, rd, 3'b000, immLow[7:0]};
            OP_LD:   word = {3'b011, rd, rs1, 9'd0};
            OP_ST:   word = {3'b101, 2'b00, rs1, rs2, 7'd0};
            OP_BRC:  word = {3'b110, 1'b0, flag, immLow};
            OP_BRZ:  word = {3'b110, 1'b1, flag, immLow};
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    assign ldiOutOfRange    = (bus.in_imm[15:8] != 8'h00);
    // Branch offsets are 11-bit signed: bits above the sign bit must replicate it.
    assign branchOutOfRange = !((&bus.in_imm[15:10]) || (~|bus.in_imm[15:10]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        setDone   = 1'b0;
        setErr    = 1'b0;
        nextCode  = ERR_RSV;
        if (start) begin
            nextState = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (bus.in_op == OP_RSV) begin
                            nextState = ERROR;
                            setErr    = 1'b1;
                            nextCode  = ERR_RSV;
                        end else if (bus.in_op == OP_END) begin
                            nextState = DONE;
                            setDone   = 1'b1;
                        end else if (word_count == FULL_COUNT) begin
                            nextState = ERROR;
                            setErr    = 1'b1;
                            nextCode  = ERR_OVERFLOW;
                        end else if (bus.in_op == OP_LDI && ldiOutOfRange) begin
                            nextState = ERROR;
                            setErr    = 1'b1;
                            nextCode  = ERR_LDI;
                        end else if ((bus.in_op == OP_BRC || bus.in_op == OP_BRZ) && branchOutOfRange) begin
                            nextState = ERROR;
                            setErr    = 1'b1;
                            nextCode  = ERR_BRANCH;
                        end else begin
                            nextState = WRITE;
                            accept    = 1'b1;
                        end
                    end
                end
                WRITE:   nextState = LOAD;
                default: nextState = state;
            endcase
        end
    end

    // A start during WRITE still lets the registered strobe finish; it only
    // rewinds the session bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imemWe     <= 1'b0;
            imemAddr   <= '0;
            imemWdata  <= '0;
            addrPtr    <= START_ADDR;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            imemWe <= accept;
            if (accept) begin
                imemAddr  <= addrPtr;
                imemWdata <= encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                    bus.in_aluop, bus.in_imm[10:0], bus.in_flag);
            end
            if (start) begin
                addrPtr    <= START_ADDR;
                word_count <= '0;
                done       <= 1'b0;
                err        <= 1'b0;
                err_code   <= 2'b00;
            end else begin
                if (state == WRITE) begin
                    addrPtr <= addrPtr + ADDR_STEP;
                    if (word_count != FULL_COUNT) word_count <= word_count + COUNT_STEP;
                end
                if (setDone) done <= 1'b1;
                if (setErr) begin
                    err      <= 1'b1;
                    err_code <= nextCode;
                end
            end
        end
    end

    assign bus.in_ready   = (state == LOAD);
    assign bus.imem_we    = imemWe;
    assign bus.imem_addr  = imemAddr;
    assign bus.imem_wdata = imemWdata;
    assign busy           = (state == LOAD) || (state == WRITE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed test-plan steps plus random
// descriptors checked against an arithmetic model of the instruction format.
`timescale 1ns/1ps
module tb_instr_encoder_loader;
  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [6:0]  aluop;
    logic [15:0] imm;
    logic        flag;
  } desc_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start = 1'b0;
  logic  sel = 1'b0;
  logic  vld = 1'b0;
  desc_t cur = '0;
  int    cycle = 0;
  int    total = 0;
  int    bad = 0;
  int    expAddr = 0;
  int    expCnt = 0;
  int    strobeCyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  instr_encoder_loader_if #(.ADDR_WIDTH(8)) ifc8 ();
  instr_encoder_loader_if #(.ADDR_WIDTH(2)) ifc2 ();

  logic       busy8, done8, err8, busy2, done2, err2;
  logic [1:0] code8, code2;
  logic [8:0] cnt8;
  logic [2:0] cnt2;

  assign ifc8.in_valid = vld & ~sel;
  assign ifc2.in_valid = vld & sel;
  assign ifc8.in_op = cur.op;     assign ifc2.in_op = cur.op;
  assign ifc8.in_rd = cur.rd;     assign ifc2.in_rd = cur.rd;
  assign ifc8.in_rs1 = cur.rs1;   assign ifc2.in_rs1 = cur.rs1;
  assign ifc8.in_rs2 = cur.rs2;   assign ifc2.in_rs2 = cur.rs2;
  assign ifc8.in_aluop = cur.aluop; assign ifc2.in_aluop = cur.aluop;
  assign ifc8.in_imm = cur.imm;   assign ifc2.in_imm = cur.imm;
  assign ifc8.in_flag = cur.flag; assign ifc2.in_flag = cur.flag;

  instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .bus(ifc8),
    .busy(busy8), .done(done8), .err(err8), .err_code(code8), .word_count(cnt8)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .bus(ifc2),
    .busy(busy2), .done(done2), .err(err2), .err_code(code2), .word_count(cnt2)
  );

  logic        oReady, oWe, oBusy, oDone, oErr;
  logic [7:0]  oAddr;
  logic [15:0] oData;
  logic [1:0]  oCode;
  logic [8:0]  oCnt;
  assign oReady = sel ? ifc2.in_ready : ifc8.in_ready;
  assign oWe    = sel ? ifc2.imem_we : ifc8.imem_we;
  assign oAddr  = sel ? {6'b0, ifc2.imem_addr} : ifc8.imem_addr;
  assign oData  = sel ? ifc2.imem_wdata : ifc8.imem_wdata;
  assign oBusy  = sel ? busy2 : busy8;
  assign oDone  = sel ? done2 : done8;
  assign oErr   = sel ? err2 : err8;
  assign oCode  = sel ? code2 : code8;
  assign oCnt   = sel ? {6'b0, cnt2} : cnt8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic desc_t mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                               input logic [1:0] rs2, input logic [6:0] aluop,
                               input logic [15:0] imm, input logic flag);
    desc_t d;
    d.op = op; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.aluop = aluop; d.imm = imm; d.flag = flag;
    return d;
  endfunction

  // Outcome: kind 0 = word written, 1 = END accepted, 2 = error with code.
  function automatic void model(input desc_t d, input int cnt, input int aw,
                                output int kind, output int code, output int word);
    int op, rd, rs1, rs2, alu, imm, fl, s;
    op = int'(d.op); rd = int'(d.rd); rs1 = int'(d.rs1); rs2 = int'(d.rs2);
    alu = int'(d.aluop); imm = int'(d.imm); fl = int'(d.flag);
    s = int'($signed(d.imm));
    kind = 2; code = 0; word = 0;
    if (op == 7) code = 0;
    else if (op == 6) kind = 1;
    else if (cnt == (1 << aw)) code = 3;
    else if (op == 1 && imm > 255) code = 1;
    else if ((op == 4 || op == 5) && (s < -1024 || s > 1023)) code = 2;
    else begin
      kind = 0;
      case (op)
        0: word = rd * 2048 + rs1 * 512 + rs2 * 128 + alu;
        1: word = 1 * 8192 + rd * 2048 + (imm % 256);
        2: word = 3 * 8192 + rd * 2048 + rs1 * 512;
        3: word = 5 * 8192 + rs1 * 512 + rs2 * 128;
        default: word = 6 * 8192 + ((op == 5) ? 4096 : 0) + fl * 2048 + (imm % 2048);
      endcase
    end
  endfunction

  function automatic desc_t rnd();
    desc_t d;
    int r;
    logic [10:0] v;
    d.rd = 2'($urandom); d.rs1 = 2'($urandom); d.rs2 = 2'($urandom);
    d.aluop = 7'($urandom); d.flag = 1'($urandom); d.imm = 16'($urandom);
    r = $urandom_range(0, 99);
    if (r < 5) d.op = 3'd7;
    else if (r < 9) d.op = 3'd6;
    else d.op = 3'($urandom_range(0, 5));
    r = $urandom_range(0, 99);
    v = 11'($urandom);
    if (d.op == 3'd1 && r < 75) d.imm = {8'h00, 8'($urandom)};
    if ((d.op == 3'd4 || d.op == 3'd5) && r < 75) d.imm = {{5{v[10]}}, v};
    return d;
  endfunction

  task automatic startSession();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    expAddr = 0; expCnt = 0;
    chk("start_busy", oBusy, 1);
    chk("start_done_clr", oDone, 0);
    chk("start_err_clr", oErr, 0);
    chk("start_code_clr", oCode, 0);
  endtask

  task automatic push(input desc_t d, output int kind);
    int code, word, aw;
    bit got;
    aw = sel ? 2 : 8;
    model(d, expCnt, aw, kind, code, word);
    @(negedge clk);
    cur = d; vld = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (oReady) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("ready_wait", got, 1);
    if (got) begin
      chk("word_count", oCnt, expCnt);
      @(posedge clk); #1;
      vld = 1'b0;
      if (kind == 0) begin
        chk("we", oWe, 1);
        chk("addr", oAddr, expAddr);
        chk("wdata", oData, word);
        chk("ready_in_write", oReady, 0);
        strobeCyc = cycle;
        expAddr = (expAddr + 1) % (1 << aw);
        if (expCnt < (1 << aw)) expCnt++;
      end else begin
        chk("no_we", oWe, 0);
        chk("ready_after", oReady, 0);
        chk("busy_after", oBusy, 0);
        chk("done", oDone, (kind == 1) ? 1 : 0);
        chk("err", oErr, (kind == 2) ? 1 : 0);
        if (kind == 2) chk("err_code", oCode, code);
      end
    end else begin
      vld = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s0, s1;
    repeat (3) @(negedge clk);
    chk("rst_ready", oReady, 0);
    chk("rst_we", oWe, 0);
    chk("rst_addr", oAddr, 0);
    chk("rst_wdata", oData, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_err", oErr, 0);
    chk("rst_code", oCode, 0);
    chk("rst_count", oCnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", oReady, 0);

    // First ALU word.
    startSession();
    push(mk(3'd0, 2'd1, 2'd2, 2'd3, 7'h05, 16'h0, 1'b0), k);
    chk("alu_const", oData, 16'h0D85);
    @(negedge clk); @(negedge clk);
    chk("alu_count", oCnt, 1);

    // Gapless burst, END.
    startSession();
    push(mk(3'd1, 2'd2, 2'd0, 2'd0, 7'h0, 16'h003C, 1'b0), k);
    chk("ldi_const", oData, 16'h303C);
    s0 = strobeCyc;
    push(mk(3'd2, 2'd3, 2'd1, 2'd0, 7'h0, 16'h0, 1'b0), k);
    chk("ld_const", oData, 16'h7A00);
    chk("spacing1", strobeCyc - s0, 2);
    s1 = strobeCyc;
    push(mk(3'd3, 2'd0, 2'd1, 2'd2, 7'h0, 16'h0, 1'b0), k);
    chk("st_const", oData, 16'hA300);
    chk("spacing2", strobeCyc - s1, 2);
    s0 = strobeCyc;
    push(mk(3'd5, 2'd0, 2'd0, 2'd0, 7'h0, 16'hFFFE, 1'b1), k);
    chk("brz_const", oData, 16'hDFFE);
    chk("brz_addr", oAddr, 3);
    chk("spacing3", strobeCyc - s0, 2);
    push(mk(3'd6, 2'd0, 2'd0, 2'd0, 7'h0, 16'h0, 1'b0), k);
    chk("end_kind", k, 1);

    // Error codes and recovery via start.
    startSession();
    push(mk(3'd4, 2'd0, 2'd0, 2'd0, 7'h0, 16'h0400, 1'b0), k);
    chk("brc_kind", k, 2);
    startSession();
    push(mk(3'd0, 2'd0, 2'd1, 2'd2, 7'h11, 16'h0, 1'b0), k);
    chk("restart_addr", oAddr, 0);
    startSession();
    push(mk(3'd1, 2'd1, 2'd0, 2'd0, 7'h0, 16'h0100, 1'b0), k);
    startSession();
    push(mk(3'd7, 2'd0, 2'd0, 2'd0, 7'h0, 16'h0, 1'b0), k);

    // Random descriptors against the model.
    startSession();
    for (int i = 0; i < 60; i++) begin
      push(rnd(), k);
      if (k != 0) startSession();
    end

    // Small memory: overflow after 2^ADDR_WIDTH words.
    sel = 1'b1;
    startSession();
    for (int i = 0; i < 4; i++) begin
      push(mk(3'd0, 2'(i), 2'd1, 2'd2, 7'(i + 9), 16'h0, 1'b0), k);
      chk("small_addr", oAddr, i);
    end
    push(mk(3'd0, 2'd1, 2'd1, 2'd1, 7'h01, 16'h0, 1'b0), k);
    chk("ovf_kind", k, 2);
    chk("ovf_code", oCode, 3);
    chk("ovf_count", oCnt, 4);
    startSession();
    for (int i = 0; i < 25; i++) begin
      push(rnd(), k);
      if (k != 0) startSession();
    end
    sel = 1'b0;

    // Reset during WRITE.
    startSession();
    push(mk(3'd0, 2'd3, 2'd3, 2'd3, 7'h7F, 16'h0, 1'b0), k);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", oWe, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_addr", oAddr, 0);
    chk("arst_wdata", oData, 0);
    chk("arst_count", oCnt, 0);
    chk("arst_ready", oReady, 0);
    @(negedge clk); rst_n = 1'b1;

    // Start coinciding with a WRITE cycle.
    startSession();
    push(mk(3'd0, 2'd1, 2'd1, 2'd1, 7'h01, 16'h0, 1'b0), k);
    push(mk(3'd0, 2'd2, 2'd2, 2'd2, 7'h02, 16'h0, 1'b0), k);
    push(mk(3'd0, 2'd3, 2'd3, 2'd3, 7'h03, 16'h0, 1'b0), k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expAddr = 0; expCnt = 0;
    chk("midw_we", oWe, 0);
    chk("midw_ready", oReady, 1);
    chk("midw_count", oCnt, 0);
    push(mk(3'd1, 2'd0, 2'd0, 2'd0, 7'h0, 16'h00AA, 1'b0), k);
    chk("midw_addr", oAddr, 0);

    // Start coinciding with a LOAD handshake drops the descriptor.
    @(negedge clk); @(negedge clk);
    cur = mk(3'd0, 2'd1, 2'd0, 2'd0, 7'h44, 16'h0, 1'b0);
    vld = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; start = 1'b0;
    expAddr = 0; expCnt = 0;
    chk("drop_we", oWe, 0);
    chk("drop_ready", oReady, 1);
    push(mk(3'd2, 2'd1, 2'd2, 2'd0, 7'h0, 16'h0, 1'b0), k);
    chk("drop_addr", oAddr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the toycpu. It accepts symbolic instruction descriptors over a valid/ready handshake and packs each one into the 16-bit toycpu instruction word. It writes each encoded word into instruction memory at consecutive addresses. It sits between the host/boot path and the instruction RAM, and produces exactly the word format the CPU decode stage consumes.

## Interface
- ADDR_WIDTH, 8, instruction memory address width
- BASE_ADDR, 0, first address written after start

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin or restart a load session
- in_valid  in  1  descriptor valid
- in_ready  out  1  block can accept a descriptor
- in_op  in  3  0 ALU, 1 LDI, 2 LD, 3 ST, 4 BRC, 5 BRZ, 6 END, 7 reserved
- in_rd, in_rs1, in_rs2  in  2 each  register fields
- in_aluop  in  7  ALU operation field
- in_imm  in  16  LDI immediate or branch offset (two's complement)
- in_flag  in  1  branch-taken flag value
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_WIDTH  write address
- imem_wdata  out  16  encoded instruction
- busy  out  1  session active (LOAD or WRITE)
- done  out  1  END received; sticky until start
- err  out  1  sticky error until start
- err_code  out  2  00 reserved op, 01 LDI range, 10 branch range, 11 memory overflow
- word_count  out  ADDR_WIDTH+1  words written this session

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- Reset: state IDLE. All outputs are 0, including in_ready, imem_we, imem_addr, imem_wdata, done, err, err_code and word_count.
- start in any state: go to LOAD, set address to BASE_ADDR, clear word_count, done, err and err_code.
- IDLE, DONE, ERROR: in_ready = 0; only start is honoured.
- LOAD: in_ready = 1. A handshake (in_valid & in_ready) evaluates checks in this priority order:
  - in_op = 7 -> ERROR, code 00.
  - END -> DONE, no write.
  - Session already holds 2^ADDR_WIDTH words -> ERROR, code 11.
  - LDI with in_imm[15:8] != 0 -> ERROR, code 01.
  - BRC/BRZ with in_imm[15:10] not all equal -> ERROR, code 10.
  - Otherwise register the encoded word and go to WRITE.
- Encoding, with opcode in [15:13]:
  - ALU: 000, rd[12:11], rs1[10:9], rs2[8:7], aluop[6:0].
  - LDI: 001, rd[12:11], [10:8] = 0, imm[7:0].
  - LD: 011, rd[12:11], rs1[10:9] (address register), [8:0] = 0.
  - ST: 101, [12:11] = 0, rs1[10:9] (address register), rs2[8:7] (data register), [6:0] = 0.
  - BRC: 110, [12] = 0, [11] = flag, imm[10:0].
  - BRZ: 110, [12] = 1, [11] = flag, imm[10:0].
- WRITE: imem_we = 1 for exactly one cycle, with imem_addr and imem_wdata stable. The address then increments and wraps modulo 2^ADDR_WIDTH. word_count increments. Return to LOAD.
- Errors and END never produce a write strobe. imem_addr and imem_wdata hold their last values outside WRITE.

## Timing
- imem_we, imem_addr and imem_wdata are registered outputs.
- Handshake in cycle N -> imem_we high in cycle N+1 -> in_ready high again in N+2. Sustained throughput is one word per 2 cycles.
- in_ready is 0 during WRITE. Descriptors must be held until accepted.
- done and err assert in the cycle after the offending or END handshake.
- start coinciding with a WRITE cycle: that write still completes (strobe already registered). The next state is LOAD with the address at BASE_ADDR and word_count = 0.
- start coinciding with a LOAD handshake: start wins and the descriptor is dropped.
- rst_n low at any time, including mid-WRITE: immediate return to the reset state; imem_we drops asynchronously.
- word_count saturates at 2^ADDR_WIDTH.

## Test plan
- Reset, then start. ALU rd=1 rs1=2 rs2=3 aluop=0x05 -> one strobe, addr 0x00, wdata 0x0D85, word_count 1.
- Burst with no gaps:
  - LDI rd=2 imm=0x003C -> 0x303C at addr 0.
  - LD rd=3 rs1=1 -> 0x7A00 at addr 1.
  - ST rs1=1 rs2=2 -> 0xA300 at addr 2.
  - BRZ flag=1 imm=0xFFFE -> 0xDFFE at addr 3.
  - END -> done = 1 with no strobe, and strobes are exactly 2 cycles apart.
- BRC flag=0 imm=0x0400 -> err = 1, code 10, no strobe, in_ready 0. Then start -> err clears and address returns to BASE_ADDR.
- LDI imm=0x0100 -> err code 01. Reserved in_op=7 -> err code 00.
- ADDR_WIDTH=2: four ALU words -> addrs 0..3. The fifth -> err code 11, no strobe, word_count 4.
- Assert rst_n low during the WRITE cycle -> imem_we and busy drop immediately and all outputs are 0. Start pulsed mid-session -> the next write lands at BASE_ADDR.
